// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing the shared-memory multi-cycle RV32I
// datapath (fetch, decode, execute, memory, write-back). It drives the
// datapath register enables and mux selects, handles the memory req/ready
// handshake, traps on illegal encodings and counts retired instructions.
//
// Optional build macro CTRL_MEM_TIMEOUT_EN: adds a TIMEOUT_W-bit memory-wait
// counter. A request that stays unanswered for 2^TIMEOUT_W-1 cycles traps
// with cause 10. Without the macro the FSM waits for mem_ready indefinitely.
module multicycle_controller #(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             zero,
  input  logic             lt,
  input  logic             bge,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_JALR   = 4'd11;
  localparam logic [3:0] S_LUI    = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_JALR = 7'd103;
  localparam logic [6:0] OP_LUI  = 7'd55;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_OLD = 2'b01;
  localparam logic [1:0] SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // One bundle per cycle of datapath controls; cleared as a whole in reset.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctl;
    logic [2:0] imm_src;
    logic [1:0] result_src;
  } ctrl_t;

  logic [3:0]       state, nxt;
  logic [1:0]       cause, cause_q;
  logic [CNT_W-1:0] instret_q;
  logic             timeout;
  ctrl_t            ctrl, ctrl_out;

  // A non-positive width would make the timeout compare meaningless.
  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    logic unused_cfg;
    assign unused_cfg = 1'b0;
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wait_cnt;

  // The wait that would bring the count to all-ones gives up; a ready
  // arriving on that same cycle still completes normally.
  assign timeout = !mem_ready && (wait_cnt == WAIT_LAST);

  // Wait counter: restarts on every state change, counts unanswered requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wait_cnt <= '0;
    else if (nxt != state)            wait_cnt <= '0;
    else if (ctrl.mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state, trap cause and per-state datapath controls.
  always_comb begin
    ctrl  = '0;
    nxt   = state;
    cause = CAUSE_ILLEGAL;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write   = 1'b1;
          ctrl.pc_write   = 1'b1;
          ctrl.src_a      = SRCA_PC;
          ctrl.src_b      = SRCB_4;
          ctrl.alu_ctl    = ALU_ADD;
          ctrl.result_src = RES_ALU;
          nxt             = S_DECODE;
        end else if (timeout) begin
          nxt   = S_TRAP;
          cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Precompute OldPC + imm so branch/JAL targets land in ALUOut.
        ctrl.src_a   = SRCA_OLD;
        ctrl.src_b   = SRCB_IMM;
        ctrl.alu_ctl = ALU_ADD;
        ctrl.imm_src = (opcode == OP_BR)  ? IMM_B :
                       (opcode == OP_JAL) ? IMM_J : IMM_I;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXEC_R;
          OP_I:         nxt = S_EXEC_I;
          OP_BR:        nxt = S_BRANCH;
          OP_JAL:       nxt = S_JAL;
          OP_JALR:      nxt = S_JALR;
          OP_LUI:       nxt = S_LUI;
          default:      nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.src_a   = SRCA_RS1;
        ctrl.src_b   = SRCB_IMM;
        ctrl.alu_ctl = ALU_ADD;
        ctrl.imm_src = (opcode == OP_SW) ? IMM_S : IMM_I;
        nxt          = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
        else if (timeout) begin
          nxt   = S_TRAP;
          cause = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
        nxt             = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        if (mem_ready) nxt = S_FETCH;
        else if (timeout) begin
          nxt   = S_TRAP;
          cause = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_R: begin
        ctrl.src_a = SRCA_RS1;
        ctrl.src_b = SRCB_RS2;
        nxt        = S_ALUWB;
        case ({func7, func3})
          {7'h00, 3'b000}: ctrl.alu_ctl = ALU_ADD;
          {7'h20, 3'b000}: ctrl.alu_ctl = ALU_SUB;
          {7'h00, 3'b110}: ctrl.alu_ctl = ALU_OR;
          {7'h00, 3'b111}: ctrl.alu_ctl = ALU_AND;
          {7'h00, 3'b010}: ctrl.alu_ctl = ALU_SLT;
          {7'h00, 3'b011}: ctrl.alu_ctl = ALU_SLTU;
          default:         nxt = S_TRAP;
        endcase
      end
      S_EXEC_I: begin
        ctrl.src_a   = SRCA_RS1;
        ctrl.src_b   = SRCB_IMM;
        ctrl.imm_src = IMM_I;
        nxt          = S_ALUWB;
        case (func3)
          3'b000:  ctrl.alu_ctl = ALU_ADD;
          3'b100:  ctrl.alu_ctl = ALU_XOR;
          3'b110:  ctrl.alu_ctl = ALU_OR;
          3'b010:  ctrl.alu_ctl = ALU_SLT;
          3'b011:  ctrl.alu_ctl = ALU_SLTU;
          default: nxt = S_TRAP;
        endcase
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        nxt             = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut already holds the target; PC loads it only when taken.
        ctrl.src_a      = SRCA_RS1;
        ctrl.src_b      = SRCB_RS2;
        ctrl.alu_ctl    = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        nxt             = S_FETCH;
        case (func3)
          3'b000:  ctrl.pc_write = zero;
          3'b001:  ctrl.pc_write = !zero;
          3'b100:  ctrl.pc_write = lt;
          3'b101:  ctrl.pc_write = bge;
          default: nxt = S_TRAP;
        endcase
      end
      S_JALR: begin
        ctrl.src_a   = SRCA_RS1;
        ctrl.src_b   = SRCB_IMM;
        ctrl.imm_src = IMM_I;
        ctrl.alu_ctl = ALU_ADD;
        nxt          = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while ALUOut picks up OldPC + 4.
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.src_a      = SRCA_OLD;
        ctrl.src_b      = SRCB_4;
        ctrl.alu_ctl    = ALU_ADD;
        nxt             = S_ALUWB;
      end
      S_LUI: begin
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMM;
        ctrl.reg_write  = 1'b1;
        nxt             = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nxt;
  end

  // Trap cause latched on the way into TRAP, then held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cause_q <= 2'b00;
    else if (state != S_TRAP && nxt == S_TRAP)   cause_q <= cause;
  end

  // Retired count: an instruction retires when the FSM comes back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  instret_q <= '0;
    else if (state != S_FETCH && nxt == S_FETCH) instret_q <= instret_q + 1'b1;
  end

  // FETCH asserts mem_req combinationally, so hold every control low in reset.
  assign ctrl_out   = rst_n ? ctrl : '0;
  assign mem_req    = ctrl_out.mem_req;
  assign MemWrite   = ctrl_out.mem_write;
  assign AdrSrc     = ctrl_out.adr_src;
  assign IRWrite    = ctrl_out.ir_write;
  assign PCWrite    = ctrl_out.pc_write;
  assign RegWrite   = ctrl_out.reg_write;
  assign ALUSrcA    = ctrl_out.src_a;
  assign ALUSrcB    = ctrl_out.src_b;
  assign ALUControl = ctrl_out.alu_ctl;
  assign ImmSrc     = ctrl_out.imm_src;
  assign ResultSrc  = ctrl_out.result_src;
  assign trap       = rst_n && (state == S_TRAP);
  assign trap_cause = rst_n ? cause_q : 2'b00;
  assign instret    = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed steps followed by random instructions.
// Expected latency and per-instruction control activity come from a
// table-driven model of the instruction set timing; the bench answers
// memory requests with chosen wait counts.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        zero, lt, bge, mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, trap_cause;
  logic [2:0]  ALUControl, ImmSrc;
  logic        trap;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;
  int model_instret = 0;
  bit noise = 1'b0;

  // Accepted R-type {func7,func3} codes and their ALU ops; same for I-type.
  logic [9:0] r_code [6] = '{{7'h00,3'd0}, {7'h20,3'd0}, {7'h00,3'd7},
                             {7'h00,3'd6}, {7'h00,3'd2}, {7'h00,3'd3}};
  int         r_alu  [6] = '{0, 1, 2, 3, 5, 6};
  logic [2:0] i_f3   [5] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3};
  int         i_alu  [5] = '{0, 4, 3, 5, 6};
  logic [2:0] b_f3   [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

  multicycle_controller #(.CNT_W(32), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .bge(bge), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA,
            ALUSrcB, ALUControl, ImmSrc, ResultSrc, trap, trap_cause};
  endfunction

  // Instruction-level timing model: cycle count, enable counts and ALU op.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int fw, input int mw, input logic z, input logic l, input logic g,
                       output int cyc, output int rw, output int pcw, output int mwc,
                       output int req, output int alu, output bit legal);
    bit taken;
    legal = 1'b1; rw = 0; pcw = 1; mwc = 0; req = fw + 1; alu = 7; cyc = 0;
    case (op)
      7'd3:   begin cyc = 5 + fw + mw; rw = 1; req += mw + 1; alu = 0; end
      7'd35:  begin cyc = 4 + fw + mw; mwc = mw + 1; req += mw + 1; alu = 0; end
      7'd51: begin
        legal = 1'b0;
        for (int k = 0; k < 6; k++) if (r_code[k] == {f7, f3}) begin legal = 1'b1; alu = r_alu[k]; end
        cyc = legal ? 4 + fw : 3 + fw; rw = legal ? 1 : 0;
      end
      7'd19: begin
        legal = 1'b0;
        for (int k = 0; k < 5; k++) if (i_f3[k] == f3) begin legal = 1'b1; alu = i_alu[k]; end
        cyc = legal ? 4 + fw : 3 + fw; rw = legal ? 1 : 0;
      end
      7'd99: begin
        legal = (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 5);
        taken = (f3 == 0 && z) || (f3 == 1 && !z) || (f3 == 4 && l) || (f3 == 5 && g);
        cyc = 3 + fw; alu = 1; pcw = (legal && taken) ? 2 : 1;
      end
      7'd111: begin cyc = 4 + fw; rw = 1; pcw = 2; end
      7'd103: begin cyc = 5 + fw; rw = 1; pcw = 2; alu = 0; end
      7'd55:  begin cyc = 3 + fw; rw = 1; end
      default: begin legal = 1'b0; cyc = 2 + fw; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_outs", 64'(all_outs()), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_instret = 0;
  endtask

  // Runs one instruction from FETCH; starts and ends just after a falling edge.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int fw, input int mw,
                           input logic z, input logic l, input logic g);
    int e_cyc, e_rw, e_pcw, e_mwc, e_req, e_alu;
    bit legal, done;
    int cyc, n_rw, n_pcw, n_mwc, n_req, n_ir, rw_at, alu_seen, wc, tgt;
    logic [31:0] start;
    model(op, f3, f7, fw, mw, z, l, g, e_cyc, e_rw, e_pcw, e_mwc, e_req, e_alu, legal);
    opcode = op; func3 = f3; func7 = f7; zero = z; lt = l; bge = g;
    start = instret; done = 1'b0;
    cyc = 0; n_rw = 0; n_pcw = 0; n_mwc = 0; n_req = 0; n_ir = 0; rw_at = 0; alu_seen = 7; wc = 0;
    #1;
    for (int k = 0; k < 80 && !done; k++) begin
      if (mem_req) begin
        tgt = AdrSrc ? mw : fw;
        if (wc == tgt) begin mem_ready = 1'b1; wc = 0; end
        else begin mem_ready = 1'b0; wc++; end
      end else begin
        mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      cyc++;
      if (RegWrite) begin n_rw++; rw_at = cyc; end
      if (PCWrite)  n_pcw++;
      if (MemWrite) n_mwc++;
      if (mem_req)  n_req++;
      if (IRWrite)  n_ir++;
      if (ALUSrcA == 2'b10) alu_seen = int'(ALUControl);
      @(posedge clk); #1;
      if (instret !== start || trap === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check({tag, "_finished"}, 64'(done), 64'd1);
    check({tag, "_cycles"}, 64'(cyc), 64'(e_cyc));
    check({tag, "_regwrite"}, 64'(n_rw), 64'(e_rw));
    if (e_rw != 0) check({tag, "_regwrite_last"}, 64'(rw_at), 64'(cyc));
    check({tag, "_pcwrite"}, 64'(n_pcw), 64'(e_pcw));
    check({tag, "_memwrite"}, 64'(n_mwc), 64'(e_mwc));
    check({tag, "_memreq"}, 64'(n_req), 64'(e_req));
    check({tag, "_irwrite"}, 64'(n_ir), 64'd1);
    if (legal) begin
      model_instret++;
      check({tag, "_aluop"}, 64'(alu_seen), 64'(e_alu));
    end
    check({tag, "_instret"}, 64'(instret), 64'(model_instret));
    check({tag, "_trap"}, 64'(trap), 64'(!legal));
    if (!legal) begin
      check({tag, "_cause"}, 64'(trap_cause), 64'd1);
      for (int k = 0; k < 20; k++) begin
        mem_ready = k[0];
        #1;
        check({tag, "_trap_idle"}, 64'({IRWrite, PCWrite, RegWrite, mem_req, MemWrite, trap}), 64'd1);
        check({tag, "_trap_instret"}, 64'(instret), 64'(model_instret));
        @(negedge clk);
      end
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    int idx;
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; func3 = '0; func7 = '0;
    zero = 1'b0; lt = 1'b0; bge = 1'b0;
    #2;
    check("reset_outs", 64'(all_outs()), 64'd0);
    check("reset_instret", 64'(instret), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_mem_req", 64'({mem_req, AdrSrc}), 64'b10);

    // add x3,x1,x2 with zero-wait memory
    run_instr("add", 7'd51, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr("lw_wait3", 7'd3, 3'd2, 7'h00, 0, 3, 0, 0, 0);
    run_instr("beq_taken", 7'd99, 3'd0, 7'h00, 0, 0, 1, 0, 0);
    run_instr("beq_not", 7'd99, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr("jalr", 7'd103, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr("sw_wait2", 7'd35, 3'd2, 7'h00, 1, 2, 0, 0, 0);
    run_instr("lui", 7'd55, 3'd5, 7'h11, 2, 0, 0, 0, 0);
    run_instr("bad_op", 7'h7F, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr("add", 7'd51, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr("r_mext", 7'd51, 3'd0, 7'h01, 0, 0, 0, 0, 0);

    // Random instructions; stray mem_ready pulses outside memory states.
    noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      f7 = 7'h00; f3 = 3'd0; op = 7'd0;
      case ($urandom_range(0, 9))
        0: begin op = 7'd3;  f3 = 3'd2; end
        1: begin op = 7'd35; f3 = 3'd2; end
        2, 3: begin idx = $urandom_range(0, 5); op = 7'd51; {f7, f3} = r_code[idx]; end
        4: begin idx = $urandom_range(0, 4); op = 7'd19; f3 = i_f3[idx]; f7 = 7'($urandom); end
        5: begin idx = $urandom_range(0, 3); op = 7'd99; f3 = b_f3[idx]; end
        6: op = 7'd111;
        7: op = 7'd103;
        8: op = 7'd55;
        default: begin
          case ($urandom_range(0, 3))
            0: op = 7'h0F;
            1: begin op = 7'd51; f7 = 7'h01; f3 = 3'($urandom); end
            2: begin op = 7'd19; f3 = 3'd1; end
            default: begin op = 7'd99; f3 = 3'd2; end
          endcase
        end
      endcase
      run_instr("rand", op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom));
    end
    noise = 1'b0;

    // Reset in the middle of a load: instret must not count it.
    run_instr("pre_abort", 7'd19, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    opcode = 7'd3; func3 = 3'd2; mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    do_reset();
    #1;
    check("abort_instret", 64'(instret), 64'd0);
    check("abort_fetch", 64'({mem_req, AdrSrc}), 64'b10);
    run_instr("post_abort", 7'd51, 3'd0, 7'h20, 0, 0, 0, 0, 0);

`ifdef CTRL_MEM_TIMEOUT_EN
    begin
      int waits;
      opcode = 7'd51; mem_ready = 1'b0; waits = 0;
      while (trap !== 1'b1 && waits < 40) begin
        @(posedge clk); #1;
        waits++;
      end
      check("timeout_cycles", 64'(waits), 64'd15);
      check("timeout_cause", 64'(trap_cause), 64'd2);
      do_reset();
      repeat (5) @(negedge clk);
      do_reset();
      #1;
      check("timeout_rst_instret", 64'(instret), 64'd0);
      check("timeout_rst_trap", 64'({trap, mem_req}), 64'b01);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle RV32I control unit: a Moore/Mealy FSM sequencing the shared-memory multi-cycle datapath through fetch, decode, execute, memory and write-back. Instructions take 3-5 cycles plus memory wait states. Memory uses a req/ready handshake. Illegal encodings trap, and a parametrised retired-instruction counter is provided. Sits beside the datapath and drives its register enables and mux selects.

## Interface
- CNT_W, 32: width of retired-instruction counter `instret`.
- TIMEOUT_W, 4: width of memory-wait counter; only used with CTRL_MEM_TIMEOUT_EN.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction register [6:0].
- func3  input  3  IR[14:12].
- func7  input  7  IR[31:25].
- zero, lt, bge  input  1 each  ALU compare flags, valid in BRANCH.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held until mem_ready.
- MemWrite  output  1  request is a store.
- AdrSrc  output  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite, PCWrite, RegWrite  output  1 each  register enables.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
- ImmSrc  output  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- ResultSrc  output  2  00 = ALUOut, 01 = mem data, 10 = ALU result, 11 = ImmExt.
- trap  output  1  sticky halt indication.
- trap_cause  output  2  01 = illegal instruction, 10 = memory timeout.
- instret  output  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, TRAP. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req = 1, AdrSrc = 0.
  - On mem_ready: IRWrite, PCWrite, A = 00, B = 10, add, ResultSrc = 10, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: A = 01, B = 01, add. ImmSrc = 2 for opcode 99, 4 for opcode 111, else 0.
  - Next state by opcode:
    - 3 or 35 -> MEMADR
    - 51 -> EXEC_R
    - 19 -> EXEC_I
    - 99 -> BRANCH
    - 111 -> JAL
    - 103 -> JALR
    - 55 -> LUI
    - anything else -> TRAP with cause 01.
- MEMADR: A = 10, B = 01, add; ImmSrc = 0 for lw, 1 for sw. Then go to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req, AdrSrc = 1; on mem_ready go to MEMWB. MEMWB: ResultSrc = 01, RegWrite, then go to FETCH.
- MEMWR: mem_req, MemWrite, AdrSrc = 1; on mem_ready go to FETCH.
- EXEC_R: A = 10, B = 00. Accepted {func7, func3}: add, sub, or, and, slt, sltu with the codes above. Any other combination -> TRAP 01.
- EXEC_I: A = 10, B = 01, ImmSrc = 0. Accepted func3: 000 addi, 100 xori, 110 ori, 010 slti, 011 sltiu. Any other -> TRAP 01.
- EXEC_R and EXEC_I both go to ALUWB. ALUWB: ResultSrc = 00, RegWrite, then go to FETCH.
- BRANCH:
  - Outputs: A = 10, B = 00, sub, ResultSrc = 00.
  - PCWrite when taken: beq (zero), bne (!zero), blt (lt), bge (bge).
  - Other func3 -> TRAP 01. Otherwise go to FETCH.
- JALR: A = 10, B = 01, ImmSrc = 0, add; ALUOut = target. Then go to JAL.
- JAL: ResultSrc = 00, PCWrite (PC <- ALUOut target). Same cycle: A = 01, B = 10, add, so ALUOut <- OldPC + 4. Then go to ALUWB.
- LUI: ImmSrc = 3, ResultSrc = 11, RegWrite, then go to FETCH.
- TRAP: all enables 0, trap = 1, trap_cause held; stays in TRAP until reset.
- instret: increments by 1, wrapping at 2^CNT_W, on every transition into FETCH from a non-FETCH state.

## Timing
- Reset: state = FETCH, instret = 0, trap = 0, trap_cause = 00. While rst_n is low every output is 0, including mem_req.
- First mem_req is asserted in the first cycle after rst_n deasserts.
- Zero-wait latencies in cycles:
  - 3: branch, LUI
  - 4: R/I-type, sw, JAL
  - 5: lw, JALR
  - Each memory wait cycle adds 1.
- Handshake:
  - mem_req, AdrSrc and MemWrite stay stable until the mem_ready cycle.
  - Completion happens in the same cycle that mem_ready is sampled high.
  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction aborts it immediately; instret does not count the aborted instruction.

## Configuration
- CTRL_MEM_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready is low.
  - When it reaches 2^TIMEOUT_W - 1 with mem_ready still low: go to TRAP with cause 10.
  - mem_ready arriving on that same cycle wins.
- Undefined: no counter; the FSM waits for mem_ready indefinitely and cause 10 never occurs.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready tied 1 -> FETCH, DECODE, EXEC_R, ALUWB; RegWrite in cycle 4 with ALUControl 000; instret = 1.
- lw with 3 wait cycles on the data read -> mem_req and AdrSrc = 1 held for 4 cycles in MEMRD; MEMWB one cycle after ready; 8 cycles total.
- beq in two runs, zero = 1 then zero = 0 -> PCWrite = 1 in BRANCH only when zero = 1; both runs return to FETCH after 3 cycles.
- JALR -> JAL -> ALUWB; PCWrite in JAL with ResultSrc 00; RegWrite in ALUWB; instret + 1.
- Opcode 0x7F, or R-type with func7 0x01 -> TRAP; trap = 1, cause 01; all enables 0 for 20+ cycles; instret frozen.
- With CTRL_MEM_TIMEOUT_EN and TIMEOUT_W = 4, mem_ready held 0 in FETCH -> TRAP with cause 10 after 15 wait cycles. rst_n pulsed low mid-wait -> FETCH, instret = 0.
